multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction
//  instead of single-cycle decode. Drives datapath enables per state, stalls on memory
//  handshake, and counts retired instructions. Sits between instruction register and datapath.
// PARAMETERS
//  OPCODE_W  6   opcode/funct field width
//  ALUOP_W   2   alu_op width (00 add, 01 sub, 10 funct-decoded)
//  CNT_W     16  retired-instruction counter width
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous reset, active low
//  opcode      in   OPCODE_W IR[31:26], valid from DECODE onward
//  funct       in   OPCODE_W IR[5:0]
//  zero        in   1        ALU zero flag, sampled in BRANCH
//  mem_ready   in   1        memory handshake: access completes in cycle it is high
//  ir_write    out  1        load IR (FETCH, with mem_ready)
//  pc_write    out  1        unconditional PC load
//  pc_write_cond out 1       PC load if branch taken
//  pc_src      out  2        00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
//  iord        out  1        0 PC address, 1 ALUOut address
//  mem_read    out  1        memory read request
//  mem_write   out  1        memory write request
//  mem_to_reg  out  1        writeback from MDR
//  reg_dst     out  2        00 rt, 01 rd, 10 $31
//  reg_write   out  1        register file write
//  alu_src_a   out  1        0 PC, 1 rs
//  alu_src_b   out  2        00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//  alu_op      out  ALUOP_W  ALU control class
//  state       out  4        current state encoding (debug)
//  instr_cnt   out  CNT_W    retired-instruction count
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=FETCH(0), instr_cnt=0; all outputs combinational from state,
//    so in reset all enables 0 except FETCH outputs once rst_n releases.
//  - States: 0 FETCH,1 DECODE,2 MEMADR,3 MEMRD,4 MEMWB,5 MEMWR,6 RTEX,7 RTWB,
//    8 BRANCH,9 JUMP,10 ADDIEX,11 ADDIWB,12 JR,13 JALWB,14 ILLEGAL (macro only).
//  - FETCH: mem_read=1,iord=0,alu_src_a=0,alu_src_b=01,alu_op=00; when mem_ready: ir_write=1,
//    pc_write=1,pc_src=00 -> DECODE; else hold FETCH (no enables except mem_read).
//  - DECODE: alu_src_a=0,alu_src_b=11,alu_op=00 (branch target). Next by opcode:
//    100011/101011->MEMADR; 000000 & funct=001000->JR; 000000 other->RTEX; 000100/000101->BRANCH;
//    001000->ADDIEX; 000010->JUMP; 000011->JUMP (jal); others->FETCH (NOP) or ILLEGAL with macro.
//  - MEMADR: alu_src_a=1,alu_src_b=10,alu_op=00 -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: mem_read=1,iord=1; wait for mem_ready -> MEMWB. MEMWR: mem_write=1,iord=1; on
//    mem_ready -> FETCH (retire). mem_read/mem_write stay asserted every waiting cycle.
//  - MEMWB: reg_write=1,reg_dst=00,mem_to_reg=1 -> FETCH (retire).
//  - RTEX: alu_src_a=1,alu_src_b=00,alu_op=10 -> RTWB: reg_write=1,reg_dst=01 -> FETCH (retire).
//  - ADDIEX: alu_src_a=1,alu_src_b=10,alu_op=00 -> ADDIWB: reg_write=1,reg_dst=00 -> FETCH.
//  - BRANCH: alu_src_a=1,alu_src_b=00,alu_op=01,pc_src=01; pc_write_cond=1 iff
//    (beq & zero) | (bne & ~zero); opcode latched in DECODE selects polarity -> FETCH (retire).
//  - JUMP: pc_write=1,pc_src=10; if opcode=000011 -> JALWB (reg_write=1,reg_dst=10, writes
//    old PC+4) -> FETCH; else -> FETCH. JR: pc_write=1,pc_src=11 -> FETCH.
//  - Retire = last state of instruction transitions to FETCH; instr_cnt+1 that edge, wraps
//    2^CNT_W-1 -> 0. NOP opcode in DECODE also retires.
//  - rst_n low mid-instruction (incl. mem wait): abort, FETCH next cycle, count cleared.
//  - Latency (mem_ready tied 1): lw 5, sw 4, R/addi 4, beq/bne/j/jr 3, jal 4 cycles.
// CONFIGURATION
//  MCFSM_ILLEGAL_TRAP_EN defined: unknown opcode -> ILLEGAL(14), all enables 0, state held
//    until reset; instr_cnt not incremented. Undefined: unknown opcode treated as NOP -> FETCH.
// TESTING
//  - Reset: rst_n=0 two cycles -> state=0, instr_cnt=0, mem_read=1 after release.
//  - lw, mem_ready=1: states 0,1,2,3,4,0; reg_write=1 & mem_to_reg=1 in state 4; instr_cnt=1.
//  - sw, mem_ready low 3 cycles in MEMWR: mem_write held 4 cycles, then FETCH, no reg_write.
//  - beq zero=1 -> pc_write_cond=1; bne zero=1 -> pc_write_cond=0; both retire (cnt +1 each).
//  - jal: JUMP pc_src=10, JALWB reg_dst=10 reg_write=1; jr (op 0, funct 0x08): pc_src=11.
//  - opcode 111111: without macro -> FETCH, cnt+1; with macro -> state 14 held, rst_n recovers.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS control unit sequencing FETCH/DECODE/EXECUTE/MEM/WB per instruction, with retired-instruction counter
// Ports: clk, rst_n (sync, active low); opcode/funct from IR; zero from ALU; mem_ready memory handshake;
//   datapath controls ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, mem_to_reg,
//   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op; debug state; instr_cnt retired count.
// Option: define MCFSM_ILLEGAL_TRAP_EN to trap unknown opcodes in ILLEGAL (held until reset) instead of NOP.
module multicycle_control_fsm #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [1:0]          reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_cnt
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB,
    BRANCH, JUMP, ADDIEX, ADDIWB, JR, JALWB, ILLEGAL
  } state_t;
  localparam logic [OPCODE_W-1:0] OP_RT   = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2b);
  localparam logic [OPCODE_W-1:0] FN_JR   = OPCODE_W'(6'h08);
  state_t st, nxt;
  logic retire;
  // opcode captured in DECODE so later states do not depend on the IR staying stable
  logic [OPCODE_W-1:0] op_q;
  assign state = st;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= FETCH;
      instr_cnt <= '0;
      op_q      <= '0;
    end else begin
      st <= nxt;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
      if (st == DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    nxt           = st;
    retire        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_W'(2'b00);
    case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) nxt = MEMADR;
        else if (opcode == OP_RT) nxt = funct == FN_JR ? JR : RTEX;
        else if (opcode == OP_BEQ || opcode == OP_BNE) nxt = BRANCH;
        else if (opcode == OP_ADDI) nxt = ADDIEX;
        else if (opcode == OP_J || opcode == OP_JAL) nxt = JUMP;
        else begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
          nxt = ILLEGAL;
`else
          nxt    = FETCH;
          retire = 1'b1;
`endif
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = op_q == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        nxt      = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = FETCH;
        retire     = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        nxt       = mem_ready ? FETCH : MEMWR;
        retire    = mem_ready;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(2'b10);
        nxt       = RTWB;
      end
      RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        nxt       = FETCH;
        retire    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        nxt       = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(2'b01);
        pc_src        = 2'b01;
        pc_write_cond = (op_q == OP_BEQ && zero) || (op_q == OP_BNE && !zero);
        nxt           = FETCH;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        nxt      = op_q == OP_JAL ? JALWB : FETCH;
        retire   = op_q != OP_JAL;
      end
      JALWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b10;
        nxt       = FETCH;
        retire    = 1'b1;
      end
      JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        nxt      = FETCH;
        retire   = 1'b1;
      end
      ILLEGAL: nxt = ILLEGAL;
      default: nxt = FETCH;
    endcase
  end
endmodule
